apu_pwm_mixer: RTL and testbench

Parametrised successor to the single-channel APU PWM output stage. It accepts a frame of CHANNELS unsigned samples through a valid/ready handshake, applies a per-channel mute mask, and sums the channels over CHANNELS cycles with a time-multiplexed adder. It saturates the sum to PWM_W bits and drives a PWM output whose duty is updated only at period boundaries, so pulses are never torn. It sits between the APU channel generators and the external 4 kHz low-pass filter pin.

---
 rtl/apu_pkg.sv | 23 ++
 rtl/pwm_gen.sv | 39 +++
 rtl/apu_pwm_mixer.sv | 116 +++++++++++
 tb/tb_apu_pwm_mixer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared types and helpers for the APU PWM mixer: FSM state encoding,
// accumulator sizing and the duty saturation limit.
package apu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mix_state_e;

  localparam int DEF_PWM_W = 8;
  localparam int DUTY_MAX  = (1 << DEF_PWM_W) - 1;

  // Wide enough that summing every channel at full scale cannot wrap.
  function automatic int acc_width(input int channels, input int sample_w);
    return sample_w + $clog2(channels + 1);
  endfunction

  function automatic int duty_max(input int pwm_w);
    return (1 << pwm_w) - 1;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// PWM generator: prescaled tick, free-running counter, duty latched only at
// the period wrap so a pulse is never torn, registered compare output.
module pwm_gen #(
  parameter int PWM_W    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] duty,
  output logic             pwm
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]  pre_q;
  logic [PWM_W-1:0] cnt_q;
  logic [PWM_W-1:0] active_q;
  logic             tick;

  assign tick = (pre_q == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      active_q <= '0;
      pwm      <= 1'b0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PS_W'(1);
      if (tick) begin
        cnt_q <= cnt_q + PWM_W'(1);
        // Sampled before any same-edge duty update, so the old duty wins.
        if (cnt_q == '1) active_q <= duty;
      end
      pwm <= (cnt_q < active_q);
    end
  end

endmodule

// File: rtl/apu_pwm_mixer.sv
// APU channel mixer: accepts a frame of CHANNELS samples, sums unmuted
// channels one per cycle, saturates to PWM_W bits and drives pwm_gen.
module apu_pwm_mixer
  import apu_pkg::*;
#(
  parameter int CHANNELS = 5,
  parameter int SAMPLE_W = 7,
  parameter int PWM_W    = 8,
  parameter int PRESCALE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*SAMPLE_W-1:0] in_samples,
  input  logic [CHANNELS-1:0]          in_mute,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         mix_done,
  output logic [PWM_W-1:0]             duty,
  output logic                         clip,
  input  logic                         clip_clr,
  output logic                         pwm
);

  localparam int ACC_W = acc_width(CHANNELS, SAMPLE_W);
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CMP_W = ((ACC_W > PWM_W) ? ACC_W : PWM_W) + 1;

  function automatic logic is_over(input logic [ACC_W-1:0] a);
    return CMP_W'(a) > CMP_W'(duty_max(PWM_W));
  endfunction

  function automatic logic [PWM_W-1:0] sat_duty(input logic [ACC_W-1:0] a);
    if (is_over(a)) return '1;
    return PWM_W'(a);
  endfunction

  mix_state_e state_q, state_d;

  logic [CHANNELS*SAMPLE_W-1:0] samples_p0;
  logic [CHANNELS-1:0]          mute_p0;
  logic [ACC_W-1:0]             acc_p1;
  logic [IDX_W-1:0]             idx_q;
  logic [SAMPLE_W-1:0]          cur_sample;
  logic [ACC_W-1:0]             acc_next;
  logic                         last_ch;

  always_comb begin
    cur_sample = samples_p0[idx_q*SAMPLE_W +: SAMPLE_W];
    acc_next   = acc_p1 + (mute_p0[idx_q] ? '0 : ACC_W'(cur_sample));
    last_ch    = (idx_q == IDX_W'(CHANNELS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    mix_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ACCUM;
      end
      ACCUM: if (last_ch) state_d = DONE;
      DONE: begin
        mix_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: frame capture on handshake
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      samples_p0 <= in_samples;
      mute_p0    <= in_mute;
    end
  end

  // Stage p1: serial accumulate; the result is registered on the last channel
  // so duty is already valid during the DONE cycle alongside mix_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p1 <= '0;
      idx_q  <= '0;
      duty   <= '0;
      clip   <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        acc_p1 <= '0;
        idx_q  <= '0;
      end else if (state_q == ACCUM) begin
        acc_p1 <= acc_next;
        idx_q  <= idx_q + IDX_W'(1);
        if (last_ch) duty <= sat_duty(acc_next);
      end
      if (state_q == ACCUM && last_ch && is_over(acc_next)) clip <= 1'b1;
      else if (clip_clr)                                    clip <= 1'b0;
    end
  end

  pwm_gen #(
    .PWM_W   (PWM_W),
    .PRESCALE(PRESCALE)
  ) u_pwm_gen (
    .clk (clk),
    .rst (rst),
    .duty(duty),
    .pwm (pwm)
  );

endmodule

// File: tb/tb_apu_pwm_mixer.sv
// Scoreboard bench for apu_pwm_mixer: a driver pushes expected mix results,
// a monitor pops them on mix_done; PWM shape is checked per period.
module tb_apu_pwm_mixer;

  localparam int CH = 5;
  localparam int SW = 7;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [CH*SW-1:0] in_samples = '0;
  logic [CH-1:0]    in_mute    = '0;
  logic             in_valid   = 1'b0;
  logic             clip_clr   = 1'b0;
  logic             in_ready, mix_done, clip, pwm;
  logic [PW-1:0]    duty;
  logic             in_ready3, mix_done3, clip3, pwm3;
  logic [PW-1:0]    duty3;

  apu_pwm_mixer #(.CHANNELS(CH), .SAMPLE_W(SW), .PWM_W(PW), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .in_samples(in_samples), .in_mute(in_mute),
    .in_valid(in_valid), .in_ready(in_ready), .mix_done(mix_done),
    .duty(duty), .clip(clip), .clip_clr(clip_clr), .pwm(pwm));

  apu_pwm_mixer #(.CHANNELS(CH), .SAMPLE_W(SW), .PWM_W(PW), .PRESCALE(3)) dut3 (
    .clk(clk), .rst(rst), .in_samples(in_samples), .in_mute(in_mute),
    .in_valid(in_valid), .in_ready(in_ready3), .mix_done(mix_done3),
    .duty(duty3), .clip(clip3), .clip_clr(clip_clr), .pwm(pwm3));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int exp_duty;
    bit exp_clip;
    int t_acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   clip_m = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain sum of unmuted channels.
  function automatic int ref_mix(input logic [CH*SW-1:0] s, input logic [CH-1:0] m);
    int sum = 0;
    for (int k = 0; k < CH; k++) if (!m[k]) sum += int'(s[k*SW +: SW]);
    return sum;
  endfunction

  always @(negedge clk) begin
    if (!rst && mix_done) begin
      if (sb.size() == 0) check("unexpected_mix_done", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("duty", int'(duty), mon_e.exp_duty);
        check("clip_at_done", int'(clip), int'(mon_e.exp_clip));
        check("mix_latency", cyc - mon_e.t_acc, CH + 1);
      end
    end
  end

  task automatic send_frame(input logic [CH*SW-1:0] s, input logic [CH-1:0] m,
                            input bit keep, input bit clr_held, output int t_acc);
    int   sum;
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    in_samples = s;
    in_mute    = m;
    in_valid   = 1'b1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("handshake_timeout", 0, 1);
      in_valid = 1'b0;
      t_acc    = -1;
      return;
    end
    t_acc      = cyc;
    sum        = ref_mix(s, m);
    e.exp_duty = (sum > 255) ? 255 : sum;
    e.exp_clip = (sum > 255) || (clip_m && !clr_held);
    e.t_acc    = cyc;
    clip_m     = e.exp_clip;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mix_done && n < 50);
    if (!mix_done) check("mix_done_timeout", 0, 1);
  endtask

  task automatic settle(input int p);
    repeat (2 * 256 * p + 8) @(negedge clk);
  endtask

  task automatic wait_rise(input bit sel, output bit ok);
    logic prev;
    prev = sel ? pwm3 : pwm;
    ok   = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if ((sel ? pwm3 : pwm) && !prev) begin
        ok = 1'b1;
        return;
      end
      prev = sel ? pwm3 : pwm;
    end
    check("pwm_rise_timeout", 0, 1);
  endtask

  // Called at a rising edge of pwm; returns at the next rising edge.
  task automatic count_period(input bit sel, output int len, output int hi);
    logic prev, cur;
    len  = 1;
    hi   = 1;
    prev = 1'b1;
    for (int n = 0; n < 2500; n++) begin
      @(negedge clk);
      cur = sel ? pwm3 : pwm;
      if (cur && !prev) return;
      len++;
      hi += int'(cur);
      prev = cur;
    end
    len = -1;
  endtask

  task automatic measure(input bit sel, input int p, input int d, input string name);
    bit ok;
    int len, hi;
    wait_rise(sel, ok);
    if (ok) begin
      count_period(sel, len, hi);
      check({name, "_period"}, len, 256 * p);
      check({name, "_high"}, hi, d * p);
    end
  endtask

  function automatic logic [CH*SW-1:0] rand_frame();
    logic [CH*SW-1:0] f;
    for (int k = 0; k < CH; k++) f[k*SW +: SW] = SW'($urandom_range(0, 127));
    return f;
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, t_prev, bad, hi, len, n;
    bit ok;
    logic [CH*SW-1:0] f;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_duty", int'(duty), 0);
    check("reset_clip", int'(clip), 0);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b1 || duty !== '0 || clip !== 1'b0 || pwm !== 1'b0 ||
          mix_done !== 1'b0 || pwm3 !== 1'b0) bad++;
    end
    check("reset_idle_512", bad, 0);

    // Plain sum 5 x 0x10 = 80
    send_frame({CH{7'h10}}, '0, 1'b0, 1'b0, t);
    wait_done();
    settle(1);
    measure(1'b0, 1, 80, "pwm80");

    // Full scale saturates and sets sticky clip
    send_frame({CH{7'h7F}}, '0, 1'b0, 1'b0, t);
    wait_done();
    repeat (20) @(negedge clk);
    check("clip_sticky", int'(clip), 1);
    settle(1);
    measure(1'b0, 1, 255, "pwm255");
    clip_clr = 1'b1;
    @(negedge clk);
    clip_clr = 1'b0;
    clip_m   = 1'b0;
    check("clip_cleared", int'(clip), 0);
    clip_clr = 1'b1;
    send_frame({CH{7'h7F}}, '0, 1'b0, 1'b1, t);
    wait_done();
    clip_clr = 1'b0;
    @(negedge clk);
    check("clip_set_beats_clr", int'(clip), 1);

    // Mute masks
    send_frame({{(CH-1){7'h7F}}, 7'h20}, 5'b11110, 1'b0, 1'b0, t);
    wait_done();
    send_frame({CH{7'h7F}}, 5'b11111, 1'b0, 1'b0, t);
    wait_done();
    settle(1);
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      hi += int'(pwm);
    end
    check("pwm_duty0_silent", hi, 0);

    // Continuous in_valid: accepts spaced CH+2 apart
    t_prev = -1;
    for (int i = 0; i < 4; i++) begin
      f = (i % 2 == 0) ? {CH{7'h05}} : {CH{7'h11}};
      send_frame(f, '0, 1'b1, 1'b0, t);
      if (t_prev >= 0) check("accept_spacing", t - t_prev, CH + 2);
      t_prev = t;
    end
    in_valid = 1'b0;
    wait_done();

    // Mid-period duty update must not tear the current pulse
    send_frame({CH{7'h10}}, '0, 1'b0, 1'b0, t);
    wait_done();
    settle(1);
    wait_rise(1'b0, ok);
    if (ok) begin
      fork
        count_period(1'b0, len, hi);
        begin
          repeat (94) @(negedge clk);
          send_frame({CH{7'h28}}, '0, 1'b0, 1'b0, t);
        end
      join
      check("tear_old_period_len", len, 256);
      check("tear_old_period_high", hi, 80);
      count_period(1'b0, len, hi);
      check("tear_new_period_len", len, 256);
      check("tear_new_period_high", hi, 200);
    end

    // Prescaled instance sees the same duty stretched by 3
    check("dut3_duty", int'(duty3), int'(duty));
    settle(3);
    measure(1'b1, 3, 200, "pwm_prescale3");

    // Random frames against the reference
    for (int i = 0; i < 20; i++) begin
      f = rand_frame();
      send_frame(f, CH'($urandom_range(0, 31)), 1'b0, 1'b0, t);
    end
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end

    // Reset mid-accumulation aborts the frame
    send_frame({CH{7'h33}}, '0, 1'b0, 1'b0, t);
    @(negedge clk);
    @(negedge clk);
    void'(sb.pop_back());
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    clip_m = 1'b0;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_duty", int'(duty), 0);
    check("abort_mix_done", int'(mix_done), 0);
    check("abort_clip", int'(clip), 0);
    repeat (20) @(negedge clk);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
